laundry_scheduler: RTL

Shares a pool of `NUM_MACHINES` washing machine controllers among paying customers. Each accepted coin (plus its second-wash choice) is queued in a FIFO. Queued requests are dispatched round-robin to idle, lid-closed, non-faulted machines. A request is popped only after the machine acknowledges it by raising its busy indication. The block sits between the coin acceptor front panel and the per-machine `washingmachine` FSM instances, driving each instance's `coin` and `second_wash` inputs.

---
 rtl/laundry_pkg.sv | 43 ++++
 rtl/laundry_scheduler_if.sv | 38 +++
 rtl/req_fifo.sv | 67 ++++++
 rtl/laundry_scheduler.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/laundry_pkg.sv
// laundry_pkg: shared types, default parameters and the round-robin picker
// for the laundry scheduler.
//   state_e   : dispatch FSM states (IDLE, START, WAIT)
//   DEF_*     : default parameter values
//   rr_first  : first set bit of a request vector searching upward from a
//               pointer with wrap at n
package laundry_pkg;

    localparam int unsigned DEF_NUM_MACHINES = 4;
    localparam int unsigned DEF_QUEUE_DEPTH  = 8;
    localparam int unsigned DEF_ACK_TIMEOUT  = 4;
    localparam int unsigned MAX_MACHINES     = 8;
    localparam int unsigned RR_IDX_W         = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // First requester at or above ptr, wrapping modulo n (ptr < n <= 8).
    function automatic logic [RR_IDX_W-1:0] rr_first(
        input logic [MAX_MACHINES-1:0] req,
        input logic [RR_IDX_W-1:0]     ptr,
        input int unsigned             n
    );
        logic [RR_IDX_W-1:0] idx;
        logic                found;
        int unsigned         j;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_MACHINES; k++) begin
            j = 32'(ptr) + k;
            if (j >= n) j = j - n;
            if ((k < n) && !found && req[j[RR_IDX_W-1:0]]) begin
                idx   = j[RR_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/laundry_scheduler_if.sv
// laundry_scheduler_if: front-panel and machine-pool signals of the scheduler.
//   coin, second_wash, fault_clear      : front panel -> scheduler
//   machine_busy, lid_open              : machines -> scheduler
//   machine_start, machine_second_wash  : scheduler -> machines
//   queue_count, queue_full, coin_reject, machine_fault : status
// Modports: slave = scheduler, master = environment.
interface laundry_scheduler_if
    import laundry_pkg::*;
#(
    parameter int unsigned NUM_MACHINES = DEF_NUM_MACHINES,
    parameter int unsigned QUEUE_DEPTH  = DEF_QUEUE_DEPTH
) ();

    logic                               coin;
    logic                               second_wash;
    logic                               fault_clear;
    logic [NUM_MACHINES-1:0]            machine_busy;
    logic [NUM_MACHINES-1:0]            lid_open;
    logic [NUM_MACHINES-1:0]            machine_start;
    logic [NUM_MACHINES-1:0]            machine_second_wash;
    logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count;
    logic                               queue_full;
    logic                               coin_reject;
    logic [NUM_MACHINES-1:0]            machine_fault;

    modport slave (
        input  coin, second_wash, fault_clear, machine_busy, lid_open,
        output machine_start, machine_second_wash, queue_count, queue_full,
               coin_reject, machine_fault
    );

    modport master (
        output coin, second_wash, fault_clear, machine_busy, lid_open,
        input  machine_start, machine_second_wash, queue_count, queue_full,
               coin_reject, machine_fault
    );

endinterface

// File: rtl/req_fifo.sv
// req_fifo: 1-bit wide synchronous FIFO holding pending second-wash choices.
//   push_i/din_i : write (ignored when full)
//   pop_i        : discard head (ignored when empty)
//   head_o       : current head bit
//   count_o, full_o, empty_o : occupancy, registered
module req_fifo #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CW    = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          din_i,
    input  logic          pop_i,
    output logic          head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/laundry_scheduler.sv
// laundry_scheduler: queues paid requests and dispatches them round-robin to
// idle, lid-closed, non-faulted washing machines; a request leaves the queue
// only once the chosen machine reports busy.
//   clk, rst : clock, synchronous active-high reset
//   bus      : laundry_scheduler_if.slave (coin/panel inputs, machine start
//              and second-wash drives, queue status, sticky faults)
//   wash_count (only with LAUNDRY_STATS_EN): saturating acknowledged-dispatch count
module laundry_scheduler
    import laundry_pkg::*;
#(
    parameter int unsigned NUM_MACHINES = DEF_NUM_MACHINES,
    parameter int unsigned QUEUE_DEPTH  = DEF_QUEUE_DEPTH,
    parameter int unsigned ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    laundry_scheduler_if.slave   bus
`ifdef LAUNDRY_STATS_EN
    ,
    output logic [15:0]          wash_count
`endif
);

    localparam int unsigned SEL_W  = (NUM_MACHINES > 1) ? $clog2(NUM_MACHINES) : 1;
    localparam int unsigned TCNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d, rr_ptr_q, rr_ptr_d, pick_c;
    logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
    logic [NUM_MACHINES-1:0] start_q, start_d, sw_q, sw_d, fault_q, fault_d;
    logic [NUM_MACHINES-1:0] elig_c;
    logic                    reject_q, push_c, pop_c;
    logic                    fifo_head, fifo_full, fifo_empty;
    logic [CNT_W-1:0]        fifo_count;

    // Full is the registered flag, so a same-cycle pop cannot rescue a coin.
    assign push_c = bus.coin & ~fifo_full;
    assign elig_c = ~bus.machine_busy & ~bus.lid_open & ~fault_q;
    assign pick_c = SEL_W'(rr_first(MAX_MACHINES'(elig_c), RR_IDX_W'(rr_ptr_q), NUM_MACHINES));

    req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .din_i   (bus.second_wash),
        .pop_i   (pop_c),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            tcnt_q   <= '0;
            start_q  <= '0;
            sw_q     <= '0;
            fault_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            tcnt_q   <= tcnt_d;
            start_q  <= start_d;
            sw_q     <= sw_d;
            fault_q  <= fault_d;
            reject_q <= bus.coin & fifo_full;
        end
    end

    // Dispatch FSM: select -> start pulse -> wait for busy or time out.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        tcnt_d   = tcnt_q;
        start_d  = '0;
        sw_d     = sw_q;
        fault_d  = fault_q;
        pop_c    = 1'b0;
        // Clear first so a coincident timeout still records its fault.
        if (bus.fault_clear) fault_d = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && (|elig_c)) begin
                    sel_d   = pick_c;
                    state_d = START;
                end
            end
            START: begin
                start_d[sel_q] = 1'b1;
                sw_d           = '0;
                sw_d[sel_q]    = fifo_head;
                tcnt_d         = '0;
                state_d        = WAIT;
            end
            WAIT: begin
                if (bus.machine_busy[sel_q]) begin
                    pop_c    = 1'b1;
                    rr_ptr_d = (sel_q == SEL_W'(NUM_MACHINES - 1)) ? '0 : sel_q + SEL_W'(1);
                    sw_d     = '0;
                    state_d  = IDLE;
                end else if (tcnt_q == TCNT_W'(ACK_TIMEOUT - 1)) begin
                    // Head stays queued and rr_ptr is kept, so the retry
                    // skips the now-faulted machine.
                    fault_d[sel_q] = 1'b1;
                    sw_d           = '0;
                    state_d        = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef LAUNDRY_STATS_EN
    logic [15:0] wash_q;

    // Acknowledged dispatches, saturating.
    always_ff @(posedge clk) begin
        if (rst)                              wash_q <= '0;
        else if (pop_c && (wash_q != 16'hFFFF)) wash_q <= wash_q + 16'd1;
    end

    assign wash_count = wash_q;
`endif

    assign bus.machine_start       = start_q;
    assign bus.machine_second_wash = sw_q;
    assign bus.queue_count         = fifo_count;
    assign bus.queue_full          = fifo_full;
    assign bus.coin_reject         = reject_q;
    assign bus.machine_fault       = fault_q;

endmodule
